// File: rtl/led_pkg.sv
// Shared constants for the bicolour LED pattern generator.
//   - mode encodings (3 bits)
//   - broadcast address, one-shot length, tick counter width
//   - pattern_out: maps a mode plus the LED's phase and one-shot state to {yr, bg}
package led_pkg;

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_A       = 3'd1;
    localparam logic [2:0] MODE_B       = 3'd2;
    localparam logic [2:0] MODE_AB      = 3'd3;
    localparam logic [2:0] MODE_BLINK_A = 3'd4;
    localparam logic [2:0] MODE_BLINK_B = 3'd5;
    localparam logic [2:0] MODE_ALT     = 3'd6;
    localparam logic [2:0] MODE_ONESHOT = 3'd7;

    localparam logic [3:0] BCAST_ADDR    = 4'hF;
    localparam int         ONESHOT_TICKS = 4;
    localparam int         ONESHOT_W     = 3;
    localparam int         TICK_CTR_W    = 4;

    // Returns {yr, bg} for one LED.
    function automatic logic [1:0] pattern_out(input logic [2:0] mode,
                                               input logic       phase,
                                               input logic       oneshot_on);
        logic [1:0] out;
        out = 2'b00;
        case (mode)
            MODE_OFF:     out = 2'b00;
            MODE_A:       out = 2'b10;
            MODE_B:       out = 2'b01;
            MODE_AB:      out = 2'b11;
            MODE_BLINK_A: out = {phase, 1'b0};
            MODE_BLINK_B: out = {1'b0, phase};
            MODE_ALT:     out = {phase, ~phase};
            MODE_ONESHOT: out = {oneshot_on, 1'b0};
            default:      out = 2'b00;
        endcase
        return out;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Pattern time base: a prescaler counting 0..PRESCALE_DIV-1 and a free-running
// tick counter that advances once per prescaler wrap.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   tick      - one-cycle pulse while the prescaler sits at its terminal count
//   tick_ctr  - number of ticks seen, wraps 15 -> 0
module led_tick_gen
    import led_pkg::*;
#(
    parameter int PRESCALE_DIV = 1200000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  tick,
    output logic [TICK_CTR_W-1:0] tick_ctr
);

    localparam int PRE_W = $clog2(PRESCALE_DIV);

    logic [PRE_W-1:0] pre_cnt;

    assign tick = (pre_cnt == PRE_W'(PRESCALE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt  <= '0;
            tick_ctr <= '0;
        end else if (tick) begin
            pre_cnt  <= '0;
            tick_ctr <= tick_ctr + 1'b1;
        end else begin
            pre_cnt  <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Producer side of the bicolour LED multiplexer: holds a per-LED mode/rate,
// programmed via a valid/ready write port, and produces registered colour-A
// (yellow/red) and colour-B (blue/green) request vectors.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cfg_valid/ready   - write handshake (ready rises one edge after reset release)
//   cfg_addr          - LED index, 4'hF broadcasts to all LEDs
//   cfg_mode/cfg_rate - pattern mode and blink rate to load
//   cfg_err           - one-cycle pulse after a write to a nonexistent LED
//   led_yr / led_bg   - colour-A / colour-B request per LED
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_LEDS     = 12,
    parameter int PRESCALE_DIV = 1200000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [3:0]          cfg_addr,
    input  logic [2:0]          cfg_mode,
    input  logic [1:0]          cfg_rate,
    output logic                cfg_err,
    output logic [NUM_LEDS-1:0] led_yr,
    output logic [NUM_LEDS-1:0] led_bg
);

    logic                  tick;
    logic [TICK_CTR_W-1:0] tick_ctr;
    logic                  accept;
    logic                  is_bcast;
    logic                  addr_ok;
    logic [NUM_LEDS-1:0]   yr_nxt;
    logic [NUM_LEDS-1:0]   bg_nxt;

    led_tick_gen #(
        .PRESCALE_DIV (PRESCALE_DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .tick_ctr (tick_ctr)
    );

    assign accept   = cfg_valid & cfg_ready;
    assign is_bcast = (cfg_addr == BCAST_ADDR);
    assign addr_ok  = (cfg_addr < 4'(NUM_LEDS)) | is_bcast;

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        logic [2:0]           mode_q;
        logic [1:0]           rate_q;
        logic [ONESHOT_W-1:0] os_cnt_q;
        logic                 hit;

        assign hit = accept & (is_bcast | (cfg_addr == 4'(i)));

        // A write on the same edge as a tick takes priority, so a freshly
        // started one-shot always gets its full length.
        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q   <= MODE_OFF;
                rate_q   <= '0;
                os_cnt_q <= '0;
            end else if (hit) begin
                mode_q   <= cfg_mode;
                rate_q   <= cfg_rate;
                os_cnt_q <= (cfg_mode == MODE_ONESHOT) ? ONESHOT_W'(ONESHOT_TICKS) : '0;
            end else if (tick && os_cnt_q != '0) begin
                os_cnt_q <= os_cnt_q - 1'b1;
                if (os_cnt_q == ONESHOT_W'(1))
                    mode_q <= MODE_OFF;
            end
        end

        assign {yr_nxt[i], bg_nxt[i]} = pattern_out(mode_q, tick_ctr[rate_q], os_cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
            led_yr    <= '0;
            led_bg    <= '0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= accept & ~addr_ok;
            led_yr    <= yr_nxt;
            led_bg    <= bg_nxt;
        end
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Producer side of the bicolour LED multiplexer.
- Holds a per-LED mode and blink rate, programmed through a valid/ready write port.
- Generates the colour-A (yellow/red) and colour-B (blue/green) request vectors each cycle, including blink, alternate and one-shot patterns.
- Outputs connect directly to the multiplexer's led_in_yr / led_in_bg inputs.

Parameters:
- NUM_LEDS, 12, number of LEDs driven; must be 1..15.
- PRESCALE_DIV, 1200000, clk cycles per pattern tick (10 Hz at 12 MHz); must be 2 or more.

Ports:
- clk  input  1  system clock (12 MHz or faster).
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  write request.
- cfg_ready  output  1  write port can accept.
- cfg_addr  input  4  LED index; 4'hF = broadcast to all LEDs.
- cfg_mode  input  3  pattern mode (see Behaviour).
- cfg_rate  input  2  blink rate select.
- cfg_err  output  1  one-cycle pulse: accepted write had an invalid address.
- led_yr  output  NUM_LEDS  colour-A request per LED.
- led_bg  output  NUM_LEDS  colour-B request per LED.

Behaviour:
- Reset (synchronous, active-high), applied at any time, including mid-pattern or mid one-shot:
  - all modes = OFF, rates = 0, one-shot counters = 0;
  - prescaler = 0, tick counter = 0;
  - led_yr = 0, led_bg = 0, cfg_err = 0, cfg_ready = 0.
- cfg_ready is a register. It is 0 while rst is high and rises on the first edge after rst is sampled low. It then stays 1; no backpressure otherwise.
- A write is accepted on an edge where cfg_valid and cfg_ready are both 1. Only one write per cycle.
- Address handling on an accepted write:
  - addr < NUM_LEDS: that LED's mode and rate load from cfg_mode and cfg_rate on the accept edge.
  - addr = 4'hF: all LEDs load.
  - any other addr: no state change; cfg_err = 1 for exactly the following cycle.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 and wraps.
  - tick pulses for one cycle when the count equals PRESCALE_DIV-1.
  - A 4-bit tick counter increments on each tick and wraps 15 to 0.
- Phase per LED = tick_ctr[rate]. Half-period is therefore 1, 2, 4 or 8 ticks for rate 0..3.
- Mode encodings, giving (yr, bg):
  - 0 OFF: (0, 0).
  - 1 A: (1, 0).
  - 2 B: (0, 1).
  - 3 AB blend: (1, 1).
  - 4 blink A: (phase, 0).
  - 5 blink B: (0, phase).
  - 6 alternate: (phase, !phase).
  - 7 one-shot A: (cnt != 0, 0).
- One-shot (mode 7):
  - Writing mode 7 loads that LED's 3-bit counter with 4.
  - Each tick decrements any nonzero counter.
  - When the counter reaches 0, that LED's mode becomes OFF on the same edge.
  - A write and a tick on the same edge: the write wins (counter = 4, no decrement; or mode replaced).
  - Writing any other mode clears the counter.
  - Rate is ignored in this mode.
- Outputs are registered from the mode/rate/counter state and tick_ctr.
  - A write accepted at edge E is visible on led_yr/led_bg after edge E+1 (latency 2 edges from the handshake).
  - A tick at edge T changes phase-dependent outputs after edge T+1.
- Broadcast mode 7 starts all one-shots aligned. A broadcast write overrides any in-progress one-shot.

Decomposition:
- Package led_pkg holds:
  - mode constants MODE_OFF..MODE_ONESHOT (3 bits);
  - BCAST_ADDR = 4'hF;
  - ONESHOT_TICKS = 4;
  - TICK_CTR_W = 4.
- Sub-module led_tick_gen:
  - contains the prescaler and the 4-bit tick counter;
  - parameter PRESCALE_DIV;
  - outputs tick and tick_ctr.
- The top level holds the per-LED state arrays (generate loop) and the output registers.

Test Plan:
(All with PRESCALE_DIV=4, NUM_LEDS=12.)
- Reset, then release rst -> cfg_ready 0 during reset and 1 one cycle after release; led_yr = led_bg = 12'h000.
- Write addr 3 mode 1, then addr 9 mode 3 -> after latency: led_yr = 12'h208, led_bg = 12'h200; other bits stay 0.
- Write addr 0 mode 4 rate 1 -> led_yr[0] toggles every 8 clk (2 ticks); led_bg[0] stays 0. Switch to mode 6 -> led_yr[0] = !led_bg[0] every cycle.
- Write addr 5 mode 7 -> led_yr[5] = 1 for exactly 4 ticks (about 16 clk, edge-aligned to ticks), then 0. Read-back mode is OFF: led_yr[5] stays 0 through 10 further ticks. Repeat with the write coincident with a tick: full 4 ticks still observed.
- Write addr 12 mode 1 -> cfg_err high for one cycle, outputs unchanged. Write addr 15 mode 2 -> led_bg = 12'hFFF, led_yr = 12'h000.
- Assert rst mid one-shot and mid blink -> outputs 0 on the edge after rst is sampled; after release, all LEDs stay OFF until rewritten.
